// File: rtl/cr_kme_drbg_seed_sched.sv
// cr_kme_drbg_seed_sched: arbitrates the two software-loaded DRBG seed slots
// for the KDF DRBG generate engine. It counts completed generates per seed
// against that seed's reseed interval and pulses seedN_invalidate when the
// interval is used up.
// Optional feature macro: CR_KME_DRBG_SEED_RR_EN. When defined, grants
// alternate between the seeds if both are valid. When undefined, the scheduler
// stays on one seed until that seed is invalidated or goes invalid.
module cr_kme_drbg_seed_sched #(
    parameter int unsigned       CNT_W      = 48,
    parameter int unsigned       TMO_W      = 16,
    parameter logic [TMO_W-1:0]  TMO_CYCLES = TMO_W'(16'hFFFF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed0_valid,
    input  logic [CNT_W-1:0] seed0_reseed_interval,
    input  logic             seed1_valid,
    input  logic [CNT_W-1:0] seed1_reseed_interval,
    input  logic             drbg_req,
    input  logic             drbg_done,
    output logic             drbg_grant,
    output logic             drbg_seed_sel,
    output logic             drbg_no_seed,
    output logic             drbg_timeout,
    output logic             seed0_invalidate,
    output logic             seed1_invalidate
);

    localparam int unsigned CNT_XW = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        RETIRE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               active_sel_q, active_sel_d;
    logic               sel_q, sel_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;
    logic [TMO_W-1:0]   wd_q, wd_d;
    logic               grant_q, grant_d;
    logic               timeout_q, timeout_d;
    logic               inv0_q, inv0_d;
    logic               inv1_q, inv1_d;

    // Per-grant helpers: the seed picked in IDLE and the retire math for the granted seed.
    logic               choose_sel;
    logic               cur_valid;
    logic [CNT_W-1:0]   cur_cnt;
    logic [CNT_W-1:0]   cur_ivl;
    logic [CNT_W-1:0]   cnt_inc;
    logic               exhausted;
    logic [TMO_W-1:0]   wd_inc;

    assign choose_sel = active_sel_q ? (seed1_valid ? 1'b1 : 1'b0)
                                     : (seed0_valid ? 1'b0 : 1'b1);
    assign cur_valid  = sel_q ? seed1_valid : seed0_valid;
    assign cur_cnt    = sel_q ? cnt1_q : cnt0_q;
    assign cur_ivl    = sel_q ? seed1_reseed_interval : seed0_reseed_interval;
    assign cnt_inc    = (&cur_cnt) ? cur_cnt : cur_cnt + CNT_W'(1);
    assign exhausted  = (cur_ivl != '0) &&
                        ((CNT_XW'(cur_cnt) + CNT_XW'(1)) >= CNT_XW'(cur_ivl));
    assign wd_inc     = wd_q + TMO_W'(1);

    // Request-time status only; this is the single combinational output.
    assign drbg_no_seed = drbg_req && !seed0_valid && !seed1_valid;

    assign drbg_grant       = grant_q;
    assign drbg_seed_sel    = sel_q;
    assign drbg_timeout     = timeout_q;
    assign seed0_invalidate = inv0_q;
    assign seed1_invalidate = inv1_q;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            active_sel_q <= 1'b0;
            sel_q        <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            wd_q         <= '0;
            grant_q      <= 1'b0;
            timeout_q    <= 1'b0;
            inv0_q       <= 1'b0;
            inv1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_sel_q <= active_sel_d;
            sel_q        <= sel_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            wd_q         <= wd_d;
            grant_q      <= grant_d;
            timeout_q    <= timeout_d;
            inv0_q       <= inv0_d;
            inv1_q       <= inv1_d;
        end
    end

    // Next-state logic. The retire update is registered on the done edge, so
    // the invalidate pulse is visible during the RETIRE cycle.
    always_comb begin
        state_d      = state_q;
        active_sel_d = active_sel_q;
        sel_d        = sel_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        wd_d         = wd_q;
        grant_d      = 1'b0;
        timeout_d    = 1'b0;
        inv0_d       = 1'b0;
        inv1_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (drbg_req && (seed0_valid || seed1_valid)) begin
                    state_d      = BUSY;
                    grant_d      = 1'b1;
                    sel_d        = choose_sel;
                    active_sel_d = choose_sel;
                    wd_d         = '0;
                end
            end
            BUSY: begin
                wd_d = wd_inc;
                if (drbg_done) begin
                    state_d = RETIRE;
                    if (cur_valid) begin
`ifdef CR_KME_DRBG_SEED_RR_EN
                        active_sel_d = ~sel_q;
`endif
                        if (exhausted) begin
                            active_sel_d = ~sel_q;
                            if (sel_q) begin
                                inv1_d = 1'b1;
                                cnt1_d = '0;
                            end else begin
                                inv0_d = 1'b1;
                                cnt0_d = '0;
                            end
                        end else if (sel_q) begin
                            cnt1_d = cnt_inc;
                        end else begin
                            cnt0_d = cnt_inc;
                        end
                    end
                end else if ((TMO_CYCLES != '0) && (wd_inc == TMO_CYCLES)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            RETIRE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An unloaded slot (including a software reload) restarts its count.
        if (!seed0_valid) cnt0_d = '0;
        if (!seed1_valid) cnt1_d = '0;
    end

endmodule

// File: tb/tb_cr_kme_drbg_seed_sched.sv
// Directed testbench for cr_kme_drbg_seed_sched, built with TMO_CYCLES = 8.
module tb_cr_kme_drbg_seed_sched;

    localparam int unsigned CNT_W = 48;
    localparam int unsigned TMO_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             seed0_valid;
    logic [CNT_W-1:0] seed0_reseed_interval;
    logic             seed1_valid;
    logic [CNT_W-1:0] seed1_reseed_interval;
    logic             drbg_req;
    logic             drbg_done;
    logic             drbg_grant;
    logic             drbg_seed_sel;
    logic             drbg_no_seed;
    logic             drbg_timeout;
    logic             seed0_invalidate;
    logic             seed1_invalidate;

    int checks = 0;
    int errors = 0;

    cr_kme_drbg_seed_sched #(
        .CNT_W      (CNT_W),
        .TMO_W      (TMO_W),
        .TMO_CYCLES (16'd8)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .seed0_valid           (seed0_valid),
        .seed0_reseed_interval (seed0_reseed_interval),
        .seed1_valid           (seed1_valid),
        .seed1_reseed_interval (seed1_reseed_interval),
        .drbg_req              (drbg_req),
        .drbg_done             (drbg_done),
        .drbg_grant            (drbg_grant),
        .drbg_seed_sel         (drbg_seed_sel),
        .drbg_no_seed          (drbg_no_seed),
        .drbg_timeout          (drbg_timeout),
        .seed0_invalidate      (seed0_invalidate),
        .seed1_invalidate      (seed1_invalidate)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drbg_req = 1'b0;
        drbg_done = 1'b0;
        seed0_valid = 1'b0;
        seed1_valid = 1'b0;
        seed0_reseed_interval = '0;
        seed1_reseed_interval = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Issues one request and a done right after the grant. The invalidate
    // outputs are sampled in the RETIRE cycle.
    task automatic run_op(output logic ok, output logic sel, output logic i0,
                          output logic i1, output int waits);
        ok = 1'b0; sel = 1'b0; i0 = 1'b0; i1 = 1'b0; waits = 0;
        drbg_req = 1'b1;
        for (int k = 0; k < 10 && !ok; k++) begin
            tick();
            waits++;
            if (drbg_grant) begin
                ok  = 1'b1;
                sel = drbg_seed_sel;
            end
        end
        drbg_req = 1'b0;
        if (ok) begin
            drbg_done = 1'b1;
            tick();
            i0 = seed0_invalidate;
            i1 = seed1_invalidate;
            drbg_done = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({drbg_grant, drbg_seed_sel, drbg_no_seed, drbg_timeout,
             seed0_invalidate, seed1_invalidate} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {drbg_grant, drbg_seed_sel, drbg_no_seed, drbg_timeout,
                      seed0_invalidate, seed1_invalidate});
        end
        checks++;
        if (dut.cnt0_q !== 48'd0) begin
            errors++;
            $display("FAIL reset_cnt0: got %0d expected 0", dut.cnt0_q);
        end
    endtask

    task automatic test_interval3();
        logic ok, sel, i0, i1;
        int w;
        logic [CNT_W-1:0] exp_cnt;
        apply_reset();
        seed0_valid = 1'b1;
        seed0_reseed_interval = 48'd3;
        for (int n = 1; n <= 3; n++) begin
            run_op(ok, sel, i0, i1, w);
            checks++;
            if (ok !== 1'b1 || sel !== 1'b0) begin
                errors++;
                $display("FAIL int3_grant op%0d: got ok=%b sel=%b expected ok=1 sel=0", n, ok, sel);
            end
            checks++;
            if (i0 !== (n == 3) || i1 !== 1'b0) begin
                errors++;
                $display("FAIL int3_inval op%0d: got inv0=%b inv1=%b expected inv0=%b inv1=0",
                         n, i0, i1, (n == 3));
            end
            exp_cnt = (n == 3) ? 48'd0 : CNT_W'(n);
            checks++;
            if (dut.cnt0_q !== exp_cnt) begin
                errors++;
                $display("FAIL int3_cnt op%0d: got %0d expected %0d", n, dut.cnt0_q, exp_cnt);
            end
        end
    endtask

    task automatic test_failover();
        logic ok, sel, i0, i1;
        int w;
        apply_reset();
        seed0_valid = 1'b1;
        seed1_valid = 1'b1;
        seed0_reseed_interval = 48'd1;
        seed1_reseed_interval = 48'd0;
        run_op(ok, sel, i0, i1, w);
        checks++;
        if (ok !== 1'b1 || sel !== 1'b0 || i0 !== 1'b1 || i1 !== 1'b0) begin
            errors++;
            $display("FAIL failover_op1: got ok=%b sel=%b inv0=%b inv1=%b expected 1 0 1 0", ok, sel, i0, i1);
        end
        seed0_valid = 1'b0;
        for (int n = 2; n <= 3; n++) begin
            run_op(ok, sel, i0, i1, w);
            checks++;
            if (ok !== 1'b1 || sel !== 1'b1 || i0 !== 1'b0 || i1 !== 1'b0) begin
                errors++;
                $display("FAIL failover_op%0d: got ok=%b sel=%b inv0=%b inv1=%b expected 1 1 0 0",
                         n, ok, sel, i0, i1);
            end
            checks++;
            if (dut.cnt1_q !== CNT_W'(n - 1)) begin
                errors++;
                $display("FAIL failover_cnt1 op%0d: got %0d expected %0d", n, dut.cnt1_q, n - 1);
            end
        end
    endtask

    task automatic test_no_seed();
        apply_reset();
        drbg_req = 1'b1;
        tick();
        checks++;
        if (drbg_no_seed !== 1'b1 || drbg_grant !== 1'b0) begin
            errors++;
            $display("FAIL no_seed_status: got no_seed=%b grant=%b expected 1 0", drbg_no_seed, drbg_grant);
        end
        tick();
        seed1_valid = 1'b1;
        #1;
        checks++;
        if (drbg_no_seed !== 1'b0 || drbg_grant !== 1'b0) begin
            errors++;
            $display("FAIL no_seed_clear: got no_seed=%b grant=%b expected 0 0", drbg_no_seed, drbg_grant);
        end
        tick();
        checks++;
        if (drbg_grant !== 1'b1 || drbg_seed_sel !== 1'b1) begin
            errors++;
            $display("FAIL no_seed_grant: got grant=%b sel=%b expected 1 1", drbg_grant, drbg_seed_sel);
        end
        drbg_req = 1'b0;
        drbg_done = 1'b1;
        tick();
        drbg_done = 1'b0;
        tick();
    endtask

    task automatic test_mid_drop();
        apply_reset();
        seed0_valid = 1'b1;
        seed0_reseed_interval = 48'd1;
        drbg_req = 1'b1;
        tick();
        checks++;
        if (drbg_grant !== 1'b1 || drbg_seed_sel !== 1'b0) begin
            errors++;
            $display("FAIL drop_grant: got grant=%b sel=%b expected 1 0", drbg_grant, drbg_seed_sel);
        end
        drbg_req = 1'b0;
        seed0_valid = 1'b0;
        tick();
        drbg_done = 1'b1;
        tick();
        checks++;
        if (seed0_invalidate !== 1'b0 || seed1_invalidate !== 1'b0) begin
            errors++;
            $display("FAIL drop_inval: got inv0=%b inv1=%b expected 0 0", seed0_invalidate, seed1_invalidate);
        end
        drbg_done = 1'b0;
        tick();
        checks++;
        if (dut.cnt0_q !== 48'd0) begin
            errors++;
            $display("FAIL drop_cnt0: got %0d expected 0", dut.cnt0_q);
        end
    endtask

    task automatic test_watchdog();
        logic ok, sel, i0, i1;
        int w;
        int early;
        apply_reset();
        seed0_valid = 1'b1;
        seed0_reseed_interval = 48'd2;
        run_op(ok, sel, i0, i1, w);
        drbg_req = 1'b1;
        tick();
        checks++;
        if (drbg_grant !== 1'b1) begin
            errors++;
            $display("FAIL wd_grant: got %b expected 1", drbg_grant);
        end
        drbg_req = 1'b0;
        early = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (drbg_timeout !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL wd_early: got %0d early timeout cycles expected 0", early);
        end
        tick();
        checks++;
        if (drbg_timeout !== 1'b1) begin
            errors++;
            $display("FAIL wd_pulse: got %b expected 1 at grant+8", drbg_timeout);
        end
        drbg_done = 1'b1;
        tick();
        checks++;
        if (drbg_timeout !== 1'b0) begin
            errors++;
            $display("FAIL wd_pulse_width: got %b expected 0", drbg_timeout);
        end
        drbg_done = 1'b0;
        tick();
        checks++;
        if (seed0_invalidate !== 1'b0 || dut.cnt0_q !== 48'd1) begin
            errors++;
            $display("FAIL wd_late_done: got inv0=%b cnt0=%0d expected inv0=0 cnt0=1",
                     seed0_invalidate, dut.cnt0_q);
        end
        run_op(ok, sel, i0, i1, w);
        checks++;
        if (ok !== 1'b1 || i0 !== 1'b1) begin
            errors++;
            $display("FAIL wd_after: got ok=%b inv0=%b expected 1 1", ok, i0);
        end
    endtask

    task automatic test_sync_reset();
        logic ok, sel, i0, i1;
        int w;
        logic [3:0] got_sel;
        logic [3:0] exp_sel;
        apply_reset();
        seed1_valid = 1'b1;
        drbg_req = 1'b1;
        tick();
        checks++;
        if (drbg_grant !== 1'b1 || drbg_seed_sel !== 1'b1) begin
            errors++;
            $display("FAIL srst_grant: got grant=%b sel=%b expected 1 1", drbg_grant, drbg_seed_sel);
        end
        drbg_req = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({drbg_grant, drbg_seed_sel, drbg_timeout, seed0_invalidate,
             seed1_invalidate} !== 5'b0) begin
            errors++;
            $display("FAIL srst_outputs: got %b expected 00000",
                     {drbg_grant, drbg_seed_sel, drbg_timeout, seed0_invalidate, seed1_invalidate});
        end
        seed0_valid = 1'b1;
        got_sel = '0;
        for (int n = 0; n < 4; n++) begin
            run_op(ok, sel, i0, i1, w);
            got_sel[n] = sel;
            if (n == 0) begin
                checks++;
                if (ok !== 1'b1 || w != 1) begin
                    errors++;
                    $display("FAIL srst_idle: got ok=%b waits=%0d expected 1 1", ok, w);
                end
            end
        end
`ifdef CR_KME_DRBG_SEED_RR_EN
        exp_sel = 4'b1010;
`else
        exp_sel = 4'b0000;
`endif
        checks++;
        if (got_sel !== exp_sel) begin
            errors++;
            $display("FAIL srst_sel_order: got %b expected %b (bit0 = first op)", got_sel, exp_sel);
        end
    endtask

    initial begin
        test_reset();
        test_interval3();
        test_failover();
        test_no_seed();
        test_mid_drop();
        test_watchdog();
        test_sync_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
